// File: rtl/arith_req_scheduler_pkg.sv
// Shared definitions for the arithmetic request scheduler.
//   W        - operand/result width
//   op_e     - result-mux select codes of the four arithmetic units
//   state_e  - scheduler FSM states
package arith_pkg;

  localparam int W = 16;

  typedef enum logic [1:0] {
    OP_FL_ADD = 2'b00,
    OP_FL_MUL = 2'b01,
    OP_FI_ADD = 2'b10,
    OP_FI_MUL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_HOLD = 2'b01,
    S_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/arith_req_scheduler_if.sv
// Request/response handshake bundle between two requesters and the scheduler.
//   req_valid/req_ready  - per-requester request handshake (bit i = requester i)
//   req{0,1}_op/_a/_b    - per-requester op code and operands
//   rsp_*                - tagged response handshake back to the requesters
// master: requester side, slave: scheduler side.
interface arith_req_scheduler_if #(
  parameter int W = 16
);
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req0_op;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic [1:0]   req1_op;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_result;
  logic         rsp_overflow;

  modport master (
    output req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow
  );

  modport slave (
    input  req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow
  );
endinterface

// File: rtl/arith_req_scheduler_rr_arbiter2.sv
// Two-input round-robin grant, purely combinational.
//   req      in  2  request valids
//   prio     in  1  requester that wins when both are valid
//   grant    out 2  one-hot grant, zero when nothing is requested
//   grant_id out 1  index of the granted requester
//   any      out 1  at least one request present
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] grant,
  output logic       grant_id,
  output logic       any
);
  always_comb begin
    any      = |req;
    // A single requester always wins; prio only breaks ties.
    grant_id = (req == 2'b11) ? prio : req[1];
    grant    = 2'b00;
    if (any) grant = grant_id ? 2'b10 : 2'b01;
  end
endmodule

// File: rtl/arith_req_scheduler.sv
// Shares one combinational arithmetic datapath between two requesters.
// Grants one request at a time (round-robin), holds operands and op select
// on the datapath for LATENCY cycles, then returns the captured result and
// overflow tagged with the requester id.
//   clk, rst                  - clock, synchronous active-high reset
//   bus                       - request/response handshake (slave side)
//   alu_num1/alu_num2/alu_op  - operands and result-mux select to the units
//   alu_result/alu_overflow   - muxed datapath result
//   busy                      - high whenever not idle
//
// state  | meaning
// S_IDLE | waiting for a request; req_ready offered to the granted requester
// S_HOLD | operands held on the datapath while count runs down to zero
// S_RESP | result captured; rsp_valid held until rsp_ready
module arith_req_scheduler
  import arith_pkg::*;
#(
  parameter int W       = arith_pkg::W,
  parameter int LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  arith_req_scheduler_if.slave  bus,
  output logic [W-1:0]          alu_num1,
  output logic [W-1:0]          alu_num2,
  output logic [1:0]            alu_op,
  input  logic [W-1:0]          alu_result,
  input  logic                  alu_overflow,
  output logic                  busy
);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e       state, state_nxt;
  logic         prio;
  logic [3:0]   count;
  logic [1:0]   gnt;
  logic         gnt_id;
  logic         gnt_any;
  logic         accept;
  logic [1:0]   req_ready;
  logic         rsp_valid;
  logic         rsp_id;
  logic [W-1:0] rsp_result;
  logic         rsp_overflow;

  rr_arbiter2 u_arb (
    .req      (bus.req_valid),
    .prio     (prio),
    .grant    (gnt),
    .grant_id (gnt_id),
    .any      (gnt_any)
  );

  // The grant only ever selects a valid requester, so any valid in IDLE
  // is an accept.
  assign accept = (state == S_IDLE) && gnt_any;

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        req_ready = gnt;
        if (accept) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (count == 4'd0) state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      prio         <= 1'b0;
      count        <= 4'd0;
      alu_num1     <= '0;
      alu_num2     <= '0;
      alu_op       <= 2'b00;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (accept) begin
            alu_op   <= gnt_id ? bus.req1_op : bus.req0_op;
            alu_num1 <= gnt_id ? bus.req1_a  : bus.req0_a;
            alu_num2 <= gnt_id ? bus.req1_b  : bus.req0_b;
            rsp_id   <= gnt_id;
            count    <= CNT_INIT;
          end
        end
        S_HOLD: begin
          if (count == 4'd0) begin
            rsp_result   <= alu_result;
            rsp_overflow <= alu_overflow;
          end else begin
            count <= count - 4'd1;
          end
        end
        S_RESP: begin
          // Hand priority to the other requester once this response completes.
          if (bus.rsp_ready) prio <= ~rsp_id;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_id       = rsp_id;
  assign bus.rsp_result   = rsp_result;
  assign bus.rsp_overflow = rsp_overflow;
endmodule
